// File: rtl/pipelined_cla_addsub.sv
// Pipelined carry-lookahead adder/subtractor with a valid/ready handshake.
// Each stage sums one N/STAGES-bit slice, least-significant slice first.
module pipelined_cla_addsub #(
    parameter int N      = 32,
    parameter int STAGES = 2,
    parameter int GROUP  = 4
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    input  logic         Cin,
    input  logic         sub,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] Sum,
    output logic         Cout,
    output logic         Ovf,
    output logic         Zero
);

    localparam int W  = N / STAGES;
    localparam int NG = W / GROUP;
    localparam int LS = STAGES - 1;

    if ((N % STAGES) != 0 || (W % GROUP) != 0) begin : g_bad_params
        $error("pipelined_cla_addsub: N/STAGES/GROUP combination is illegal");
    end

    logic adv;

    assign adv      = !(out_valid && !out_ready);
    assign in_ready = adv;

    for (genvar s = 0; s < STAGES; s++) begin : g_st
        localparam int LO = s * W;
        localparam int HI = LO + W;

        logic            v_i;
        logic            sub_i;
        logic            c_i;
        logic [N-LO-1:0] a_up;
        logic [N-LO-1:0] b_up;
        logic [W-1:0]    a_s;
        logic [W-1:0]    b_s;
        logic [W-1:0]    s_o;
        logic            c_o;
        logic [HI-1:0]   sum_all;

        // Operand bits from LO upward arrive here; bits below LO are already summed.
        if (s == 0) begin : g_in
            assign v_i     = in_valid;
            assign sub_i   = sub;
            assign c_i     = Cin ^ sub;
            assign a_up    = A;
            assign b_up    = B;
            assign sum_all = s_o;
        end else begin : g_in
            assign v_i     = g_st[s-1].g_reg.v_q;
            assign sub_i   = g_st[s-1].g_reg.sub_q;
            assign c_i     = g_st[s-1].g_reg.c_q;
            assign a_up    = g_st[s-1].g_reg.a_q;
            assign b_up    = g_st[s-1].g_reg.b_q;
            assign sum_all = {s_o, g_st[s-1].g_reg.sum_q};
        end

        assign a_s = a_up[W-1:0];
        assign b_s = b_up[W-1:0] ^ {W{sub_i}};

        always_comb begin
            logic [W-1:0] g;
            logic [W-1:0] p;
            logic         cg;
            logic         gp;
            logic         pp;
            g   = a_s & b_s;
            p   = a_s ^ b_s;
            cg  = c_i;
            gp  = 1'b0;
            pp  = 1'b1;
            s_o = '0;
            for (int k = 0; k < NG; k++) begin
                gp = 1'b0;
                pp = 1'b1;
                for (int j = 0; j < GROUP; j++) begin
                    s_o[k*GROUP+j] = p[k*GROUP+j] ^ (gp | (pp & cg));
                    gp = g[k*GROUP+j] | (p[k*GROUP+j] & gp);
                    pp = pp & p[k*GROUP+j];
                end
                cg = gp | (pp & cg);
            end
            c_o = cg;
        end

        if (s < STAGES - 1) begin : g_reg
            logic            v_q;
            logic            sub_q;
            logic            c_q;
            logic [N-HI-1:0] a_q;
            logic [N-HI-1:0] b_q;
            logic [HI-1:0]   sum_q;

            always_ff @(posedge clk) begin
                if (!reset_n) begin
                    v_q <= 1'b0;
                end else if (adv) begin
                    v_q   <= v_i;
                    sub_q <= sub_i;
                    c_q   <= c_o;
                    a_q   <= a_up[N-LO-1:W];
                    b_q   <= b_up[N-LO-1:W];
                    sum_q <= sum_all;
                end
            end
        end
    end

    // Carry into the MSB is recovered as sum ^ a ^ b at the top bit.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            out_valid <= 1'b0;
            Sum       <= '0;
            Cout      <= 1'b0;
            Ovf       <= 1'b0;
            Zero      <= 1'b0;
        end else if (adv) begin
            out_valid <= g_st[LS].v_i;
            Sum       <= g_st[LS].sum_all;
            Cout      <= g_st[LS].c_o;
            Ovf       <= g_st[LS].s_o[W-1] ^ g_st[LS].a_s[W-1]
                       ^ g_st[LS].b_s[W-1] ^ g_st[LS].c_o;
            Zero      <= (g_st[LS].sum_all == '0);
        end
    end

endmodule

// File: tb/tb_pipelined_cla_addsub.sv
// Scoreboard bench for pipelined_cla_addsub (N=16, STAGES=2, GROUP=4).
// Driver pushes expected results on acceptance; monitor pops on output.
module tb_pipelined_cla_addsub;

    localparam int N = 16;

    typedef struct {
        logic [N-1:0] sum;
        logic         cout;
        logic         ovf;
        logic         zero;
        int           cyc;
    } exp_t;

    logic         clk;
    logic         reset_n;
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] A;
    logic [N-1:0] B;
    logic         Cin;
    logic         sub;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] Sum;
    logic         Cout;
    logic         Ovf;
    logic         Zero;

    exp_t exp_q[$];
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    bit   lat_chk = 0;
    bit   rnd_rdy = 0;

    pipelined_cla_addsub #(.N(N), .STAGES(2), .GROUP(4)) dut (
        .clk(clk),
        .reset_n(reset_n),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .A(A),
        .B(B),
        .Cin(Cin),
        .sub(sub),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .Sum(Sum),
        .Cout(Cout),
        .Ovf(Ovf),
        .Zero(Zero)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rnd_rdy) out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    // Monitor: handshake rule, stall hold, result order and values.
    initial begin
        bit          stalled;
        logic [N+3:0] snap;
        exp_t        e;
        stalled = 0;
        snap    = '0;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                exp_q.delete();
                stalled = 0;
            end else begin
                total++;
                if (in_ready !== !(out_valid && !out_ready)) begin
                    bad++;
                    $display("FAIL in_ready: got %b want %b", in_ready,
                             !(out_valid && !out_ready));
                end
                if (stalled) begin
                    total++;
                    if ({out_valid, Sum, Cout, Ovf, Zero} !== snap) begin
                        bad++;
                        $display("FAIL stall_hold: got %h want %h",
                                 {out_valid, Sum, Cout, Ovf, Zero}, snap);
                    end
                end
                stalled = out_valid && !out_ready;
                snap    = {out_valid, Sum, Cout, Ovf, Zero};
                if (out_valid && out_ready) begin
                    total++;
                    if (exp_q.size() == 0) begin
                        bad++;
                        $display("FAIL spurious: got sum=%h with nothing expected", Sum);
                    end else begin
                        e = exp_q.pop_front();
                        if (Sum !== e.sum || Cout !== e.cout || Ovf !== e.ovf
                            || Zero !== e.zero) begin
                            bad++;
                            $display("FAIL result: got sum=%h c=%b v=%b z=%b want sum=%h c=%b v=%b z=%b",
                                     Sum, Cout, Ovf, Zero, e.sum, e.cout, e.ovf, e.zero);
                        end
                        if (lat_chk) begin
                            total++;
                            if (cyc - e.cyc != 2) begin
                                bad++;
                                $display("FAIL latency: got %0d want 2", cyc - e.cyc);
                            end
                        end
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        in_valid = 0;
        repeat (n) tick();
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    function automatic exp_t model(input logic [N-1:0] a, input logic [N-1:0] b,
                                   input logic ci, input logic sb);
        exp_t         m;
        logic [N-1:0] be;
        logic [N:0]   r;
        be     = sb ? ~b : b;
        r      = {1'b0, a} + {1'b0, be} + (N+1)'(sb ? !ci : ci);
        m.sum  = r[N-1:0];
        m.cout = r[N];
        m.ovf  = (a[N-1] == be[N-1]) && (r[N-1] != a[N-1]);
        m.zero = (r[N-1:0] == '0);
        m.cyc  = 0;
        return m;
    endfunction

    task automatic send(input logic [N-1:0] a, input logic [N-1:0] b,
                        input logic ci, input logic sb, input exp_t e);
        int t;
        A        = a;
        B        = b;
        Cin      = ci;
        sub      = sb;
        in_valid = 1;
        t        = 0;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            t++;
            if (t > 200) begin
                total++;
                bad++;
                $display("FAIL accept_timeout: got in_ready=0 want 1 within 200 cycles");
                break;
            end
        end
        if (t <= 200) begin
            e.cyc = cyc;
            exp_q.push_back(e);
        end
        @(posedge clk);
        #1;
        in_valid = 0;
    endtask

    task automatic sendh(input logic [N-1:0] a, input logic [N-1:0] b,
                         input logic ci, input logic sb, input logic [N-1:0] s,
                         input logic co, input logic ov, input logic z);
        exp_t e;
        e.sum  = s;
        e.cout = co;
        e.ovf  = ov;
        e.zero = z;
        e.cyc  = 0;
        send(a, b, ci, sb, e);
    endtask

    function automatic logic [N-1:0] pick();
        logic [N-1:0] v;
        case ($urandom_range(0, 7))
            0:       v = 16'h0000;
            1:       v = 16'hFFFF;
            2:       v = 16'h8000;
            3:       v = 16'h7FFF;
            default: v = N'($urandom);
        endcase
        return v;
    endfunction

    initial begin
        logic [N-1:0] ra;
        logic [N-1:0] rb;
        logic         rc;
        logic         rs;

        reset_n   = 0;
        in_valid  = 1;
        A         = 16'h1234;
        B         = 16'h0001;
        Cin       = 0;
        sub       = 0;
        out_ready = 1;
        repeat (2) tick();
        @(negedge clk);
        chk("reset_in_ready", 32'(in_ready), 1);
        chk("reset_out_valid", 32'(out_valid), 0);
        chk("reset_sum", 32'(Sum), 0);
        chk("reset_flags", 32'({Cout, Ovf, Zero}), 0);
        @(posedge clk);
        #1;
        reset_n  = 1;
        in_valid = 0;

        lat_chk = 1;
        sendh(16'hFFFF, 16'h0001, 0, 0, 16'h0000, 1, 0, 1);
        sendh(16'h8000, 16'h0001, 0, 1, 16'h7FFF, 1, 1, 0);
        sendh(16'h0003, 16'h0005, 1, 1, 16'hFFFD, 0, 0, 0);
        sendh(16'h0001, 16'h0002, 0, 0, 16'h0003, 0, 0, 0);
        sendh(16'h7FFF, 16'h0001, 0, 0, 16'h8000, 0, 1, 0);
        sendh(16'h00FF, 16'h0F01, 0, 0, 16'h1000, 0, 0, 0);
        idle(2);
        sendh(16'h1234, 16'h4321, 1, 0, 16'h5556, 0, 0, 0);
        sendh(16'h5A5A, 16'h5A5A, 0, 1, 16'h0000, 1, 0, 1);
        sendh(16'h0000, 16'h0001, 0, 1, 16'hFFFF, 0, 0, 0);
        sendh(16'h7FFF, 16'h7FFF, 0, 0, 16'hFFFE, 0, 1, 0);
        sendh(16'h8000, 16'h8000, 0, 0, 16'h0000, 1, 1, 1);
        sendh(16'h00FF, 16'h0001, 0, 0, 16'h0100, 0, 0, 0);
        sendh(16'h000F, 16'h0001, 0, 0, 16'h0010, 0, 0, 0);
        sendh(16'h0005, 16'h0005, 1, 1, 16'hFFFF, 0, 0, 0);
        idle(3);

        // Backpressure: fill the pipe, hold out_ready low three cycles.
        lat_chk   = 0;
        out_ready = 0;
        fork
            begin
                sendh(16'h0010, 16'h0020, 0, 0, 16'h0030, 0, 0, 0);
                sendh(16'h0100, 16'h0200, 0, 0, 16'h0300, 0, 0, 0);
                sendh(16'h1111, 16'h2222, 0, 0, 16'h3333, 0, 0, 0);
                sendh(16'hF000, 16'h1000, 0, 0, 16'h0000, 1, 0, 1);
            end
            begin
                repeat (3) tick();
                @(negedge clk);
                chk("bp_in_ready", 32'(in_ready), 0);
                chk("bp_out_valid", 32'(out_valid), 1);
                @(posedge clk);
                #1;
                tick();
                out_ready = 1;
            end
        join
        idle(4);

        // Reset with two sets in flight and a set offered during reset.
        sendh(16'h0001, 16'h0001, 0, 0, 16'h0002, 0, 0, 0);
        sendh(16'h0002, 16'h0002, 0, 0, 16'h0004, 0, 0, 0);
        reset_n  = 0;
        in_valid = 1;
        A        = 16'h0005;
        B        = 16'h0005;
        @(negedge clk);
        chk("midrst_in_ready", 32'(in_ready), 1);
        @(posedge clk);
        #1;
        reset_n  = 1;
        in_valid = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("midrst_out_valid", 32'(out_valid), 0);
            @(posedge clk);
            #1;
        end
        lat_chk = 1;
        sendh(16'h4000, 16'h4000, 0, 0, 16'h8000, 0, 1, 0);
        idle(3);

        // Random traffic with random gaps and backpressure.
        lat_chk = 0;
        rnd_rdy = 1;
        for (int i = 0; i < 10000; i++) begin
            if ($urandom_range(0, 3) == 0) idle(1);
            ra = pick();
            rb = pick();
            rc = 1'($urandom_range(0, 1));
            rs = 1'($urandom_range(0, 1));
            send(ra, rb, rc, rs, model(ra, rb, rc, rs));
        end
        rnd_rdy = 0;
        tick();
        out_ready = 1;
        for (int t = 0; t < 100 && exp_q.size() != 0; t++) tick();
        chk("drain_left", 32'(exp_q.size()), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pipelined_cla_addsub.md
PIPELINED_CLA_ADDSUB -- requirements
Module: pipelined_cla_addsub

Interface
REQ-001 Parameter: N, 32, operand and result width in bits.
REQ-002 Parameter: STAGES, 2, pipeline depth; each stage resolves N/STAGES consecutive bits, LSB slice first.
REQ-003 Parameter: GROUP, 4, carry-lookahead group width inside a stage slice.
REQ-004 Parameter legality: N % STAGES == 0 and (N/STAGES) % GROUP == 0; elaboration SHALL fail otherwise.
REQ-005 clk  input  1  single clock, all state updates on rising edge.
REQ-006 reset_n  input  1  reset, synchronous, active-low.
REQ-007 in_valid  input  1  operand set presented.
REQ-008 in_ready  output  1  block accepts operand set this cycle.
REQ-009 A  input  N  operand A.
REQ-010 B  input  N  operand B.
REQ-011 Cin  input  1  carry-in (add) / borrow-in (sub).
REQ-012 sub  input  1  0 = add, 1 = subtract.
REQ-013 out_valid  output  1  result registers hold a valid result.
REQ-014 out_ready  input  1  downstream accepts result this cycle.
REQ-015 Sum  output  N  result.
REQ-016 Cout  output  1  carry-out; for sub, 1 = no borrow.
REQ-017 Ovf  output  1  two's-complement signed overflow.
REQ-018 Zero  output  1  Sum == 0.

Function
REQ-019 Add: {Cout,Sum} SHALL equal A + B + Cin, modulo 2^(N+1).
REQ-020 Sub: {Cout,Sum} SHALL equal A + ~B + !Cin (i.e. A - B - Cin, Cout = not-borrow).
REQ-021 Ovf SHALL be carry into MSB XOR carry out of MSB, using the effective (possibly inverted) B.
REQ-022 Within a slice, carries SHALL use generate/propagate lookahead per GROUP; slice carry-out SHALL be registered into the next stage.
REQ-023 Operand bits not yet summed, partial Sum bits and the sub flag SHALL be carried along in pipeline registers with the slice carry.
REQ-024 Transfer in: in_valid && in_ready; transfer out: out_valid && out_ready.
REQ-025 in_ready SHALL equal !(out_valid && !out_ready); the whole pipeline advances together or stalls together.
REQ-026 Latency: result of an accepted set SHALL appear with out_valid=1 exactly STAGES cycles after acceptance when no stall occurs.
REQ-027 Throughput: one set per cycle sustained while out_ready=1.
REQ-028 Stall: while out_valid && !out_ready, all pipeline registers, Sum, Cout, Ovf, Zero and out_valid SHALL hold unchanged.
REQ-029 Bubbles: cycles with in_valid=0 while in_ready=1 SHALL propagate as invalid slots; out_valid=0 when a bubble reaches the output.
REQ-030 Result ordering SHALL match acceptance order; no set dropped or duplicated.
REQ-031 Sum/Cout/Ovf/Zero values SHALL be don't-care while out_valid=0 but SHALL not change during a stall.
REQ-032 Simultaneous out transfer and in acceptance in same cycle SHALL be legal and lossless.

Reset
REQ-033 reset_n=0 at a rising edge SHALL clear every stage valid bit, out_valid, Sum, Cout, Ovf, Zero to 0.
REQ-034 In-flight sets at reset SHALL be discarded; none emerge afterwards.
REQ-035 During reset cycle in_ready SHALL be 1 (out_valid=0), but no set presented that cycle SHALL be accepted.
REQ-036 First acceptance possible on the first edge with reset_n=1.

Verification (N=16, STAGES=2, GROUP=4, out_ready=1 unless stated)
REQ-037 Add carry ripple across slice boundary: A=0xFFFF, B=0x0001, Cin=0, sub=0 -> 2 cycles later Sum=0x0000, Cout=1, Ovf=0, Zero=1.
REQ-038 Sub overflow: A=0x8000, B=0x0001, Cin=0, sub=1 -> Sum=0x7FFF, Cout=1, Ovf=1, Zero=0; A=0x0003, B=0x0005, Cin=1, sub=1 -> Sum=0xFFFD, Cout=0, Ovf=0.
REQ-039 Back-to-back: sets (1+2), (0x7FFF+1), (0x00FF+0x0F01) on cycles 0,1,2 -> out_valid cycles 2,3,4 with Sum 0x0003, 0x8000 (Ovf=1), 0x1000.
REQ-040 Backpressure: pipeline full, out_ready=0 for 3 cycles -> in_ready=0, outputs stable 3 cycles; on out_ready=1 results drain in order, none lost.
REQ-041 Reset mid-flight: two sets accepted, reset_n=0 one cycle -> out_valid=0 next cycle and stays 0 until new acceptance + 2 cycles.
REQ-042 Random: 10k constrained-random sets with random in_valid/out_ready vs. reference model for add/sub, all flags, order.
